// File: rtl/alu_arb_pkg.sv
// ============================================================================
// Module      : alu_arb_pkg
// Description : ALU control codes, arbiter FSM state type and an opcode
//               legality helper shared by the alu_arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [3:0] ALU_MAX_LEGAL = 4'b1001;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= ALU_MAX_LEGAL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_if.sv
// ============================================================================
// Module      : alu_arbiter_if
// Description : Two request channels and two response channels of the shared
//               ALU arbiter; slave modport is the arbiter side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_arbiter_if #(
  parameter int XLEN = 32
);
  logic            r0_valid, r1_valid;
  logic            r0_ready, r1_ready;
  logic [3:0]      r0_ctrl,  r1_ctrl;
  logic [XLEN-1:0] r0_a, r0_b, r1_a, r1_b;

  logic            s0_valid, s1_valid;
  logic            s0_ready, s1_ready;
  logic [XLEN-1:0] s0_out,   s1_out;
  logic            s0_zero,  s1_zero;
  logic            s0_less,  s1_less;
  logic            s0_err,   s1_err;

  modport master (
    output r0_valid, r1_valid, r0_ctrl, r1_ctrl, r0_a, r0_b, r1_a, r1_b,
    input  r0_ready, r1_ready,
    input  s0_valid, s1_valid, s0_out, s1_out, s0_zero, s1_zero,
    input  s0_less, s1_less, s0_err, s1_err,
    output s0_ready, s1_ready
  );

  modport slave (
    input  r0_valid, r1_valid, r0_ctrl, r1_ctrl, r0_a, r0_b, r1_a, r1_b,
    output r0_ready, r1_ready,
    output s0_valid, s1_valid, s0_out, s1_out, s0_zero, s1_zero,
    output s0_less, s1_less, s0_err, s1_err,
    input  s0_ready, s1_ready
  );
endinterface

`default_nettype wire

// File: rtl/ALU.sv
// ============================================================================
// Module      : ALU
// Description : Combinational integer ALU with zero and less-than flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ALU
  import alu_arb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  wire logic [3:0]      i_ctrl,
  input  wire logic [XLEN-1:0] i_a,
  input  wire logic [XLEN-1:0] i_b,
  output logic      [XLEN-1:0] o_out,
  output logic                 o_zero,
  output logic                 o_less
);
  localparam int c_SHW = $clog2(XLEN);

  logic [c_SHW-1:0] w_shamt;
  logic             w_slt;
  logic             w_sltu;

  assign w_shamt = i_b[c_SHW-1:0];
  assign w_slt   = ($signed(i_a) < $signed(i_b));
  assign w_sltu  = (i_a < i_b);

  always_comb begin
    o_out = '0;
    case (i_ctrl)
      ALU_ADD:  o_out = i_a + i_b;
      ALU_SUB:  o_out = i_a - i_b;
      ALU_AND:  o_out = i_a & i_b;
      ALU_OR:   o_out = i_a | i_b;
      ALU_XOR:  o_out = i_a ^ i_b;
      ALU_SLT:  o_out = {{(XLEN-1){1'b0}}, w_slt};
      ALU_SLTU: o_out = {{(XLEN-1){1'b0}}, w_sltu};
      ALU_SRL:  o_out = i_a >> w_shamt;
      ALU_SRA:  o_out = $signed(i_a) >>> w_shamt;
      ALU_SLL:  o_out = i_a << w_shamt;
      default:  o_out = '0;
    endcase
  end

  assign o_zero = (o_out == '0);
  assign o_less = (i_ctrl == ALU_SLT) ? w_slt : w_sltu;

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter/sequencer sharing one ALU between two
//               requesters, one operation in flight (IDLE -> EXEC -> RESP).
//               Optional macro ALU_ARB_OPCHK_EN flags codes 1010-1111 as err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input wire logic     clk,
  input wire logic     rst,
  alu_arbiter_if.slave bus
);
  arb_state_t      r_state, w_next_state;
  logic            r_prio, r_gid;
  logic [3:0]      r_ctrl;
  logic [XLEN-1:0] r_a, r_b, r_out;
  logic            r_zero, r_less, r_err;

  logic            w_grant, w_gid, w_resp_done;
  logic [XLEN-1:0] w_alu_out, w_res_out;
  logic            w_alu_zero, w_alu_less;
  logic            w_res_zero, w_res_less, w_res_err;

  assign w_resp_done = r_gid ? bus.s1_ready : bus.s0_ready;

  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_gid        = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.r0_valid || bus.r1_valid) begin
          w_grant      = 1'b1;
          w_gid        = (bus.r0_valid && bus.r1_valid) ? r_prio : bus.r1_valid;
          w_next_state = EXEC;
        end
      end
      EXEC:    w_next_state = RESP;
      RESP:    if (w_resp_done) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  ALU #(.XLEN(XLEN)) u_alu (
    .i_ctrl (r_ctrl),
    .i_a    (r_a),
    .i_b    (r_b),
    .o_out  (w_alu_out),
    .o_zero (w_alu_zero),
    .o_less (w_alu_less)
  );

`ifdef ALU_ARB_OPCHK_EN
  // Illegal codes bypass the ALU result with a fixed error response
  always_comb begin
    w_res_out  = w_alu_out;
    w_res_zero = w_alu_zero;
    w_res_less = w_alu_less;
    w_res_err  = 1'b0;
    if (!is_legal_op(r_ctrl)) begin
      w_res_out  = '0;
      w_res_zero = 1'b1;
      w_res_less = 1'b0;
      w_res_err  = 1'b1;
    end
  end
`else
  assign w_res_out  = w_alu_out;
  assign w_res_zero = w_alu_zero;
  assign w_res_less = w_alu_less;
  assign w_res_err  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_prio  <= 1'b0;
      r_gid   <= 1'b0;
      r_ctrl  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_out   <= '0;
      r_zero  <= 1'b0;
      r_less  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_grant) begin
        r_gid  <= w_gid;
        r_prio <= ~w_gid;
        r_ctrl <= w_gid ? bus.r1_ctrl : bus.r0_ctrl;
        r_a    <= w_gid ? bus.r1_a    : bus.r0_a;
        r_b    <= w_gid ? bus.r1_b    : bus.r0_b;
      end
      if (r_state == EXEC) begin
        r_out  <= w_res_out;
        r_zero <= w_res_zero;
        r_less <= w_res_less;
        r_err  <= w_res_err;
      end
    end
  end

  assign bus.r0_ready = w_grant & ~w_gid;
  assign bus.r1_ready = w_grant &  w_gid;
  assign bus.s0_valid = (r_state == RESP) & ~r_gid;
  assign bus.s1_valid = (r_state == RESP) &  r_gid;

  // Data registers are shared; only the valid bit selects the channel
  assign bus.s0_out  = r_out;
  assign bus.s1_out  = r_out;
  assign bus.s0_zero = r_zero;
  assign bus.s1_zero = r_zero;
  assign bus.s0_less = r_less;
  assign bus.s1_less = r_less;
  assign bus.s0_err  = r_err;
  assign bus.s1_err  = r_err;

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer that shares a single `ALU` instance between two clients, for example an integer pipeline and a CSR/debug path. Each request is captured under a valid/ready handshake. The captured operation runs on the shared ALU, and the registered result returns on that requester's own response channel. Round-robin arbitration guarantees that neither requester starves.

## Interface
- `XLEN`, 32, operand/result width; must be a power of two ≥ 8.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `r0_valid` / `r1_valid` input 1: request present.
- `r0_ready` / `r1_ready` output 1: request accepted this cycle.
- `r0_ctrl` / `r1_ctrl` input 4: ALUControl code.
- `r0_a`, `r0_b` / `r1_a`, `r1_b` input XLEN: operands.
- `s0_valid` / `s1_valid` output 1: response present.
- `s0_ready` / `s1_ready` input 1: response consumed.
- `s0_out` / `s1_out` output XLEN: ALU result.
- `s0_zero`, `s0_less` / `s1_zero`, `s1_less` output 1: ALU flags.
- `s0_err` / `s1_err` output 1: illegal control code flag (see Configuration).

## Operation
- ALU codes:
  - ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100.
  - SLT 0101, SLTU 1001.
  - SRL 0110, SRA 0111, SLL 1000.
  - Shift amount = `b[$clog2(XLEN)-1:0]`.
- Flags:
  - `zero` = (out == 0).
  - `less` = signed a<b for SLT; unsigned a<b for every other code.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `rX_valid` is high, grant one requester and pulse its `rX_ready` combinationally in the same cycle.
  - Latch ctrl, a, b and the grant id into operand registers, then go to EXEC.
  - `rX_ready` is never high outside IDLE. Both readies are never high together.
- Arbitration:
  - 1-bit priority pointer `prio`.
  - Both valid: grant `prio`.
  - One valid: grant it.
  - After every grant, `prio` ← NOT(granted id).
- EXEC: the ALU evaluates the latched operands. `out`/`zero`/`less`/`err` are registered into the response registers; go to RESP.
- RESP:
  - `sG_valid` is high for the granted id only.
  - Response data stays stable until `sG_ready`=1.
  - On that cycle, go to IDLE.
  - The other response channel holds valid=0.
- Requester rules:
  - Requesters hold `rX_valid` and operands stable until `rX_ready`.
  - A requester may drop valid without being served.
- A new request is never accepted while a response is pending, so there is at most one operation in flight.

## Timing
- Reset values: state=IDLE, `prio`=0, all `sX_valid`=0, `sX_out`=0, `sX_zero`=0, `sX_less`=0, `sX_err`=0, both `rX_ready`=0.
- Accept at cycle T (ready high), so `sG_valid` rises at T+2.
- Response ready at T+2 gives IDLE at T+3, so the earliest next accept is T+3. Peak throughput is one operation per 3 cycles.
- Backpressure: `sG_ready` low extends RESP indefinitely, and `rX_ready` stays 0 throughout.
- Simultaneous `sG_ready` and a new `rX_valid`: the response completes. The new request is accepted next cycle in IDLE, not the same cycle.
- Reset mid-operation:
  - Any in-flight or pending response is dropped.
  - `sX_valid` falls immediately (asynchronous reset).
  - `prio` returns to 0.
- Wrap-around: results are modulo 2^XLEN; ADD/SUB overflow is not flagged.

## Configuration
- `ALU_ARB_OPCHK_EN` defined:
  - Codes 1010–1111 are accepted normally but bypass the ALU.
  - Response is out=0, zero=1, less=0, err=1, with the same latency.
- `ALU_ARB_OPCHK_EN` undefined:
  - All codes pass to the ALU (illegal codes yield out=0, zero=1, less per unsigned compare).
  - `sX_err` is tied to 0.

## Structure
- `alu_arb_pkg`:
  - FSM state enum `arb_state_t`.
  - Localparams for all ALU codes (`ALU_ADD` … `ALU_SLL`).
  - `ALU_MAX_LEGAL` = 4'b1001.
  - Function `is_legal_op()`.
- One sub-module: the existing `ALU #(XLEN)`, instantiated once and driven only from the operand registers.
- Arbitration logic and FSM stay in one file.

## Test plan
- Reset, then r0 requests ADD 10,5 → r0_ready at T, s0_valid at T+2 with out=15, zero=0, less=0; s1_valid stays 0.
- r0 and r1 both valid from reset (r0 SUB 10,10; r1 SLT -3,5) → r0 served first (out=0, zero=1); r1 next (out=1, less=1); repeat both and confirm the grants alternate.
- r1 SRA 0xFFFFFFF0, 2 with s1_ready held low 5 cycles → s1_out=0xFFFFFFFC stays stable, both rX_ready stay 0, accept resumes one cycle after s1_ready.
- r0 SLTU 0xFFFFFFFD, 5 → out=0, zero=1, less=0; r0 SLL 3,36 → out=48 (shift amount masked to 4).
- Assert rst during EXEC → s0_valid/s1_valid are 0 immediately; after release, both valid → r0 is granted (prio=0).
- r0_ctrl=1111, 7, 7 → with `ALU_ARB_OPCHK_EN`: err=1, out=0, zero=1; without the macro: err=0, out=0.
